// File: rtl/trap_ctrl.sv
// Machine-mode trap/return controller: owns mstatus/mie/mtvec/mepc/mcause,
// decides trap entry and mret at M, and drives the flush and fetch redirect.
module trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        validM,
    input  logic        returnM,
    input  logic [31:0] PCM,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        Int_flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        irq_ack,
    output logic        mie_global
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRAP, RET, DRAIN} state_t;

    state_t      state_q, state_d;
    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic        meie_q, meie_d;
    logic        mtie_q, mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        ack_q, ack_d;

    logic ext_take, tmr_take, take_irq, take_ret, csr_wr;

    assign ext_take = ext_irq & meie_q;
    assign tmr_take = timer_irq & mtie_q;
    assign take_irq = (state_q == IDLE) & validM & ~returnM & st_mie_q & (ext_take | tmr_take);
    assign take_ret = (state_q == IDLE) & validM & returnM;
    // Writes outside IDLE come from instructions that are being flushed.
    assign csr_wr   = csr_we & (state_q == IDLE);

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            A_MSTATUS: begin
                csr_rdata[3] = st_mie_q;
                csr_rdata[7] = st_mpie_q;
            end
            A_MIE: begin
                csr_rdata[11] = meie_q;
                csr_rdata[7]  = mtie_q;
            end
            A_MTVEC:  csr_rdata = mtvec_q;
            A_MEPC:   csr_rdata = mepc_q;
            A_MCAUSE: csr_rdata = mcause_q;
            A_MIP: begin
                csr_rdata[11] = ext_irq;
                csr_rdata[7]  = timer_irq;
            end
            default:  csr_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        meie_d     = meie_q;
        mtie_d     = mtie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        redir_d    = 1'b0;
        redir_pc_d = redir_pc_q;
        ack_d      = 1'b0;

        if (csr_wr) begin
            case (csr_addr)
                A_MSTATUS: begin
                    st_mie_d  = csr_wdata[3];
                    st_mpie_d = csr_wdata[7];
                end
                A_MIE: begin
                    meie_d = csr_wdata[11];
                    mtie_d = csr_wdata[7];
                end
                A_MTVEC:  mtvec_d  = csr_wdata & ~32'h3;
                A_MEPC:   mepc_d   = csr_wdata & ~32'h3;
                A_MCAUSE: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (take_ret) begin
                    state_d    = RET;
                    flush_d    = 1'b1;
                    redir_d    = 1'b1;
                    redir_pc_d = mepc_d;
                end else if (take_irq) begin
                    // Trap updates override any same-cycle write to these CSRs.
                    state_d    = TRAP;
                    flush_d    = 1'b1;
                    redir_d    = 1'b1;
                    ack_d      = 1'b1;
                    redir_pc_d = mtvec_d;
                    mepc_d     = PCM & ~32'h3;
                    mcause_d   = ext_take ? {1'b1, 31'd11} : {1'b1, 31'd7};
                    st_mpie_d  = st_mie_q;
                    st_mie_d   = 1'b0;
                end
            end
            TRAP: begin
                state_d = DRAIN;
                cnt_d   = DRAIN_LOAD;
                flush_d = 1'b1;
            end
            RET: begin
                state_d   = DRAIN;
                cnt_d     = DRAIN_LOAD;
                flush_d   = 1'b1;
                st_mie_d  = st_mpie_q;
                st_mpie_d = 1'b1;
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            meie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC & ~32'h3;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            cnt_q      <= 4'd0;
            flush_q    <= 1'b0;
            redir_q    <= 1'b0;
            redir_pc_q <= 32'h0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            meie_q     <= meie_d;
            mtie_q     <= mtie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            ack_q      <= ack_d;
        end
    end

    assign Int_flush   = flush_q;
    assign pc_redirect = redir_q;
    assign redirect_pc = redir_pc_q;
    assign irq_ack     = ack_q;
    assign mie_global  = st_mie_q;

endmodule
